// File: rtl/bitplane_mac.sv
// Bit-serial signed/unsigned dot-product engine.
// Consumes one activation bit-plane per cycle against M latched weights.
module bitplane_mac #(
  parameter int M        = 16,
  parameter int PW       = 8,
  parameter int PA       = 8,
  parameter int SIGNED_W = 1,
  parameter int SIGNED_A = 1,
  localparam int ACC_W   = PA + PW + $clog2(M) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_load,
  input  logic [M*PW-1:0]         w_in,
  input  logic                    start,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [M-1:0]            a_plane,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] result,
  output logic                    busy
);

  localparam int PCW = $clog2(M) + 1;
  localparam int KW  = (PA > 2) ? $clog2(PA) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [M*PW-1:0]         w_reg;
  logic signed [ACC_W-1:0] acc;
  logic [KW-1:0]           k;

  logic                    w_we;
  logic                    acc_clr;
  logic                    accept;
  logic                    last;
  logic                    res_we;
  logic                    ov_set;
  logic                    ov_clr;

  logic [PCW-1:0]          cnt;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] plane_sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] plane_t;
  logic signed [ACC_W-1:0] acc_sum;

  // Weighted popcount of this activation plane over all weight planes.
  always_comb begin
    cnt       = '0;
    term      = '0;
    plane_sum = '0;
    for (int j = 0; j < PW; j++) begin
      cnt = '0;
      for (int l = 0; l < M; l++) begin
        cnt = cnt + PCW'(a_plane[l] & w_reg[l*PW+j]);
      end
      term = {{(ACC_W-PCW){1'b0}}, cnt} << j;
      if (SIGNED_W != 0 && j == PW - 1) begin
        plane_sum = plane_sum - term;
      end else begin
        plane_sum = plane_sum + term;
      end
    end
  end

  assign last    = (k == KW'(PA - 1));
  assign shifted = plane_sum <<< k;
  assign plane_t = (SIGNED_A != 0 && last) ? -shifted : shifted;
  assign acc_sum = acc + plane_t;

  assign a_ready = (state_q == ACCUM);
  assign busy    = (state_q != IDLE);
  assign accept  = a_ready && a_valid;

  always_comb begin
    state_d = state_q;
    w_we    = 1'b0;
    acc_clr = 1'b0;
    res_we  = 1'b0;
    ov_set  = 1'b0;
    ov_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        w_we = w_load;
        if (start) begin
          acc_clr = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && last) begin
          res_we  = 1'b1;
          ov_set  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_clr  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg     <= '0;
      acc       <= '0;
      k         <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (w_we) begin
        w_reg <= w_in;
      end
      if (acc_clr) begin
        acc <= '0;
        k   <= '0;
      end else if (accept) begin
        acc <= acc_sum;
        k   <= k + KW'(1);
      end
      if (res_we) begin
        result <= acc_sum;
      end
      if (ov_set) begin
        out_valid <= 1'b1;
      end else if (ov_clr) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
